ds2_modulator: RTL and testbench
================================

Name: ds2_modulator

Overview:
- Second-order, single-bit delta-sigma modulator. It sits directly downstream of the mixer and consumes the signed 20-bit mixed sample (mix_o) once per fast clock.
- Produces the 1-bit modulator output stream and detects integrator overload. After sustained overload it runs a clear-and-hold recovery so the loop cannot stay latched at a rail.

Parameters:
- IN_W, 20, input sample width (signed two's complement).
- ACC_W, 24, integrator width (signed); must be >= IN_W+2.
- OVL_CNT, 16, consecutive saturated enabled cycles that trigger overload.
- HOLD_CYC, 64, enabled cycles spent in HOLD after an overload.

Ports:
- clock  input  1  fast modulator clock (same domain as interp/mixer).
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  loop advance enable; when 0, all state holds.
- mod_i  input  IN_W  signed sample from mixer (mix_o).
- dout  output  1  modulator bit: 1 = +full-scale, 0 = -full-scale.
- ovl  output  1  high while the FSM is in HOLD.
- ovl_events  output  8  count of overload entries, saturating at 255.

Behaviour:
- Reset (reset=0, async): int1=0, int2=0, dout=0, ovl=0, ovl_events=0, sat_cnt=0, hold_cnt=0, state=RUN.
- F = 2^(IN_W-1) (524288 at default). The feedback term fb = +F if dout=1, else -F, taken from the current dout register.
- RUN update, on each clock edge with en=1, all in ACC_W signed arithmetic with sign-extended mod_i:
  - int1_n = sat(int1 + mod_i - fb)
  - int2_n = sat(int2 + int1 - fb), using the old int1.
  - int1 <= int1_n; int2 <= int2_n.
  - dout <= (int2_n >= 0).
- Latency: mod_i affects int1 one edge later, int2 two edges later, and dout at the same edge as int2.
- sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A cycle counts as saturated if either integrator's pre-clamp sum is at or beyond either rail.
- sat_cnt:
  - Increments on each saturated enabled RUN cycle.
  - Clears to 0 on any non-saturated enabled RUN cycle.
  - Never exceeds OVL_CNT.
- RUN -> HOLD: on the enabled edge where sat_cnt would reach OVL_CNT. On that same edge:
  - int1 <= 0, int2 <= 0, dout <= 0, ovl <= 1.
  - hold_cnt <= HOLD_CYC-1, sat_cnt <= 0.
  - ovl_events <= min(ovl_events+1, 255).
  - The overload transition takes precedence over the normal RUN update.
- HOLD:
  - Integrators stay 0, dout stays 0, mod_i is ignored.
  - hold_cnt decrements on each enabled edge.
  - On the enabled edge where hold_cnt=0: state <= RUN and ovl <= 0. The first RUN update happens on the next enabled edge.
- en=0 in any state: integrators, dout, sat_cnt, hold_cnt and state all freeze; outputs hold their last values.
- Reset asserted mid-operation (RUN or HOLD): immediate return to reset values; ovl_events is also cleared.
- Wrap-around: integrators never wrap; they clamp only. ovl_events sticks at 255.

Test Plan:
- Reset, then en=1 with mod_i=0 -> dout for the first 8 enabled edges = 1,1,1,0,0,0,0,1. int2 after edge 3 = 0; after edge 4 = -1048576. ovl stays 0.
- mod_i constant 262144 (+0.5F) for 4096 cycles -> ones density of dout in the last 4000 cycles = 0.75 ±0.01. ovl never asserts.
- Bench overrides ACC_W=22, OVL_CNT=4, HOLD_CYC=8; mod_i constant -524288 -> ovl rises within 32 cycles; ovl_events=1; int1=int2=0 and dout=0 for exactly 8 enabled edges; then RUN resumes, and overload re-triggers and increments ovl_events.
- en toggled 1,0,0,1 at random points during RUN and HOLD -> state and outputs identical to an en-always-1 run with the en=0 cycles removed.
- reset pulsed low for 3 ns mid-HOLD, asynchronous to clock -> dout, ovl and ovl_events read 0 while reset is low, with no clock edge needed; the first enabled edge after release reproduces the scenario 1 sequence.
- Force 300 overload entries (ACC_W=22, OVL_CNT=1, HOLD_CYC=1, mod_i=-524288) -> ovl_events saturates at 255 and stays there.

Source files
------------

// File: rtl/ds2_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ds2_modulator
// Purpose  : Second-order single-bit delta-sigma modulator with integrator
//            overload detection and a clear-and-hold recovery sequence.
// Ports    : clock      - fast modulator clock
//            reset      - asynchronous active-low reset
//            en         - loop advance enable (0 freezes all state)
//            mod_i      - signed IN_W-bit sample from the mixer
//            dout       - modulator bit (1 = +full-scale, 0 = -full-scale)
//            ovl        - high while recovering from an overload (HOLD)
//            ovl_events - overload entry count, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module ds2_modulator #(
  parameter int IN_W     = 20,
  parameter int ACC_W    = 24,
  parameter int OVL_CNT  = 16,
  parameter int HOLD_CYC = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic signed [IN_W-1:0] mod_i,
  output logic                   dout,
  output logic                   ovl,
  output logic [7:0]             ovl_events
);

  // Two guard bits: a sum of three ACC_W-range terms cannot overflow SUM_W.
  localparam int SUM_W  = ACC_W + 2;
  localparam int SAT_W  = $clog2(OVL_CNT + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  // Full-scale feedback magnitude 2^(IN_W-1), and the integrator rails.
  localparam logic signed [SUM_W-1:0] FB_POS  = {{(SUM_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_NEG  = -FB_POS;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [SAT_W-1:0]        SAT_LAST  = SAT_W'(OVL_CNT - 1);
  localparam logic [HOLD_W-1:0]       HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   int1_q, int1_d;
  logic signed [ACC_W-1:0]   int2_q, int2_d;
  logic                      dout_q, dout_d;
  logic [SAT_W-1:0]          sat_cnt_q, sat_cnt_d;
  logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic [7:0]                ovl_events_q, ovl_events_d;

  logic signed [SUM_W-1:0]   mod_ext, int1_ext, int2_ext, fb;
  logic signed [SUM_W-1:0]   sum1, sum2;
  logic signed [ACC_W-1:0]   int1_n, int2_n;
  logic                      sat1, sat2, any_sat;

  function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [SUM_W-1:0] s);
    logic signed [ACC_W-1:0] r;
    if (s >= ACC_MAX) begin
      r = ACC_MAX[ACC_W-1:0];
    end else if (s <= ACC_MIN) begin
      r = ACC_MIN[ACC_W-1:0];
    end else begin
      r = s[ACC_W-1:0];
    end
    return r;
  endfunction

  assign mod_ext  = {{(SUM_W-IN_W){mod_i[IN_W-1]}}, mod_i};
  assign int1_ext = {{(SUM_W-ACC_W){int1_q[ACC_W-1]}}, int1_q};
  assign int2_ext = {{(SUM_W-ACC_W){int2_q[ACC_W-1]}}, int2_q};
  assign fb       = dout_q ? FB_POS : FB_NEG;

  // Second integrator uses the pre-update int1 (classic delaying topology).
  assign sum1 = int1_ext + mod_ext - fb;
  assign sum2 = int2_ext + int1_ext - fb;

  // Touching a rail exactly already counts as saturated.
  assign sat1    = (sum1 >= ACC_MAX) || (sum1 <= ACC_MIN);
  assign sat2    = (sum2 >= ACC_MAX) || (sum2 <= ACC_MIN);
  assign any_sat = sat1 || sat2;

  assign int1_n = clamp_acc(sum1);
  assign int2_n = clamp_acc(sum2);

  always_comb begin
    state_d      = state_q;
    int1_d       = int1_q;
    int2_d       = int2_q;
    dout_d       = dout_q;
    sat_cnt_d    = sat_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    ovl_events_d = ovl_events_q;

    if (en) begin
      if (state_q == ST_HOLD) begin
        // Integrators and dout are already zero from the entry edge.
        if (hold_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end else if (any_sat && (sat_cnt_q == SAT_LAST)) begin
        // Overload entry overrides the normal loop update.
        state_d      = ST_HOLD;
        int1_d       = '0;
        int2_d       = '0;
        dout_d       = 1'b0;
        sat_cnt_d    = '0;
        hold_cnt_d   = HOLD_INIT;
        ovl_events_d = (ovl_events_q == 8'hFF) ? 8'hFF : ovl_events_q + 8'd1;
      end else begin
        int1_d    = int1_n;
        int2_d    = int2_n;
        dout_d    = ~int2_n[ACC_W-1];
        sat_cnt_d = any_sat ? sat_cnt_q + SAT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      int1_q       <= '0;
      int2_q       <= '0;
      dout_q       <= 1'b0;
      sat_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      ovl_events_q <= '0;
    end else begin
      state_q      <= state_d;
      int1_q       <= int1_d;
      int2_q       <= int2_d;
      dout_q       <= dout_d;
      sat_cnt_q    <= sat_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      ovl_events_q <= ovl_events_d;
    end
  end

  assign dout       = dout_q;
  assign ovl        = (state_q == ST_HOLD);
  assign ovl_events = ovl_events_q;

endmodule
`default_nettype wire

// File: tb/tb_ds2_modulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ds2_modulator
// Purpose  : Self-checking bench for ds2_modulator. Three instances with
//            different parameter sets share one clock; a reference model
//            pushes expected outputs to a scoreboard queue on every driven
//            cycle and they are popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds2_modulator;

  localparam int     IN_W = 20;
  localparam longint FS   = 524288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_s  [3];
  logic                   en_s   [3];
  logic signed [IN_W-1:0] mod_s  [3];
  logic                   dout_s [3];
  logic                   ovl_s  [3];
  logic [7:0]             ev_s   [3];

  ds2_modulator dut_a (
    .clock(clk), .reset(rst_s[0]), .en(en_s[0]), .mod_i(mod_s[0]),
    .dout(dout_s[0]), .ovl(ovl_s[0]), .ovl_events(ev_s[0])
  );

  ds2_modulator #(.ACC_W(22), .OVL_CNT(4), .HOLD_CYC(8)) dut_b (
    .clock(clk), .reset(rst_s[1]), .en(en_s[1]), .mod_i(mod_s[1]),
    .dout(dout_s[1]), .ovl(ovl_s[1]), .ovl_events(ev_s[1])
  );

  ds2_modulator #(.ACC_W(22), .OVL_CNT(1), .HOLD_CYC(1)) dut_c (
    .clock(clk), .reset(rst_s[2]), .en(en_s[2]), .mod_i(mod_s[2]),
    .dout(dout_s[2]), .ovl(ovl_s[2]), .ovl_events(ev_s[2])
  );

  typedef struct {
    longint i1;
    longint i2;
    bit     d;
    bit     hold_st;
    int     hold;
    int     sat;
    int     ev;
  } mstate_t;

  typedef struct {
    int k;
    bit d;
    bit o;
    int ev;
  } exp_t;

  int p_acc  [3] = '{24, 22, 22};
  int p_ovl  [3] = '{16, 4, 1};
  int p_hold [3] = '{64, 8, 1};
  int seq1   [8] = '{1, 1, 1, 0, 0, 0, 0, 1};

  mstate_t ms [3];
  mstate_t ref_m;
  exp_t    sbq [$];

  int n_chk = 0;
  int n_err = 0;
  int ones, ovl_seen, seen, hi_cnt, zl, rises, prev;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.i1 = 0; s.i2 = 0; s.d = 1'b0; s.hold_st = 1'b0;
    s.hold = 0; s.sat = 0; s.ev = 0;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input bit e, input longint x, input int k);
    mstate_t n;
    longint  fb, s1, s2, hi, lo;
    bit      sat;
    n = s;
    if (!e) return n;
    if (s.hold_st) begin
      if (s.hold == 0) n.hold_st = 1'b0;
      else             n.hold    = s.hold - 1;
      return n;
    end
    hi  = (longint'(1) << (p_acc[k] - 1)) - 1;
    lo  = -(longint'(1) << (p_acc[k] - 1));
    fb  = s.d ? FS : -FS;
    s1  = s.i1 + x - fb;
    s2  = s.i2 + s.i1 - fb;
    sat = (s1 >= hi) || (s1 <= lo) || (s2 >= hi) || (s2 <= lo);
    if (sat && (s.sat + 1 >= p_ovl[k])) begin
      n.i1 = 0; n.i2 = 0; n.d = 1'b0; n.hold_st = 1'b1;
      n.hold = p_hold[k] - 1; n.sat = 0;
      n.ev = (s.ev < 255) ? s.ev + 1 : 255;
      return n;
    end
    n.sat = sat ? s.sat + 1 : 0;
    n.i1  = (s1 > hi) ? hi : ((s1 < lo) ? lo : s1);
    n.i2  = (s2 > hi) ? hi : ((s2 < lo) ? lo : s2);
    n.d   = (n.i2 >= 0);
    return n;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance instance k by one clock and compare its outputs with the model.
  task automatic step(input int k);
    exp_t e;
    ms[k] = model_step(ms[k], en_s[k], longint'(mod_s[k]), k);
    e.k  = k;
    e.d  = ms[k].d;
    e.o  = ms[k].hold_st;
    e.ev = ms[k].ev;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_val($sformatf("dout[%0d]", e.k), 32'(dout_s[e.k]), 32'(e.d));
    check_val($sformatf("ovl[%0d]",  e.k), 32'(ovl_s[e.k]),  32'(e.o));
    check_val($sformatf("ev[%0d]",   e.k), 32'(ev_s[e.k]),   32'(e.ev));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      en_s[k]  = 1'b0;
      mod_s[k] = '0;
      ms[k]    = model_reset();
    end
    #2;
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("rst_dout[%0d]", k), 32'(dout_s[k]), 32'd0);
      check_val($sformatf("rst_ovl[%0d]",  k), 32'(ovl_s[k]),  32'd0);
      check_val($sformatf("rst_ev[%0d]",   k), 32'(ev_s[k]),   32'd0);
    end
    for (int k = 0; k < 3; k++) rst_s[k] = 1'b1;

    // Zero input from reset: known start-up bit pattern.
    en_s[0]  = 1'b1;
    mod_s[0] = '0;
    for (int i = 0; i < 8; i++) begin
      step(0);
      check_val($sformatf("s1_dout_e%0d", i + 1), 32'(dout_s[0]), 32'(seq1[i]));
    end

    // +0.5 FS DC input: ones density must settle at 0.75.
    mod_s[0] = 20'(FS / 2);
    ones = 0; ovl_seen = 0;
    for (int i = 0; i < 4096; i++) begin
      step(0);
      if (i >= 96 && dout_s[0]) ones++;
      if (ovl_s[0]) ovl_seen = 1;
    end
    check_val("s2_density_ok", 32'(ones >= 2960 && ones <= 3040), 32'd1);
    check_val("s2_no_ovl", 32'(ovl_seen), 32'd0);
    en_s[0] = 1'b0;

    // -FS input on the small-accumulator instance: overload and recovery.
    en_s[1]  = 1'b1;
    mod_s[1] = 20'(-FS);
    seen = 0;
    for (int i = 0; i < 32 && seen == 0; i++) begin
      step(1);
      if (ovl_s[1]) seen = 1;
    end
    check_val("s3_ovl_rise", 32'(seen), 32'd1);
    check_val("s3_events1", 32'(ev_s[1]), 32'd1);
    hi_cnt = seen;
    for (int i = 0; i < 40 && ovl_s[1]; i++) begin
      step(1);
      if (ovl_s[1]) hi_cnt++;
    end
    check_val("s3_hold_len", 32'(hi_cnt), 32'd8);
    seen = 0;
    for (int i = 0; i < 64 && seen == 0; i++) begin
      step(1);
      if (ovl_s[1]) seen = 1;
    end
    check_val("s3_retrig", 32'(seen), 32'd1);
    check_val("s3_events2", 32'(ev_s[1]), 32'd2);

    // Random 1,0,0,1 enable gaps must be equivalent to removing those cycles.
    ref_m = ms[1];
    zl = 0;
    for (int i = 0; i < 150; i++) begin
      if (zl > 0) begin
        en_s[1] = 1'b0;
        zl--;
      end else begin
        en_s[1] = 1'b1;
        if ($urandom_range(0, 5) == 0) zl = 2;
        ref_m = model_step(ref_m, 1'b1, longint'(mod_s[1]), 1);
      end
      step(1);
    end
    check_val("s4_dout", 32'(dout_s[1]), 32'(ref_m.d));
    check_val("s4_ovl",  32'(ovl_s[1]),  32'(ref_m.hold_st));
    check_val("s4_ev",   32'(ev_s[1]),   32'(ref_m.ev));

    // Asynchronous reset pulse in the middle of HOLD.
    en_s[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 64 && seen == 0; i++) begin
      step(1);
      if (ovl_s[1]) seen = 1;
    end
    step(1);
    step(1);
    check_val("s5_pre_ovl", 32'(ovl_s[1]), 32'd1);
    #2;
    rst_s[1] = 1'b0;
    #1;
    check_val("s5_rst_dout", 32'(dout_s[1]), 32'd0);
    check_val("s5_rst_ovl",  32'(ovl_s[1]),  32'd0);
    check_val("s5_rst_ev",   32'(ev_s[1]),   32'd0);
    ms[1] = model_reset();
    #2;
    rst_s[1] = 1'b1;
    mod_s[1] = '0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check_val($sformatf("s5_dout_e%0d", i + 1), 32'(dout_s[1]), 32'(seq1[i]));
    end
    en_s[1] = 1'b0;

    // Repeated overloads: event counter must stick at 255.
    en_s[2]  = 1'b1;
    mod_s[2] = 20'(-FS);
    rises = 0; prev = 0;
    for (int i = 0; i < 1600; i++) begin
      step(2);
      if (ovl_s[2] && prev == 0) rises++;
      prev = ovl_s[2] ? 1 : 0;
    end
    check_val("s6_entries_ge300", 32'(rises >= 300), 32'd1);
    check_val("s6_ev_sat", 32'(ev_s[2]), 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
